// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl
// Sequencer for a sliding-window convolution engine. For every output
// position (r, c) it clears the accumulator, walks the KxK kernel window
// issuing image/kernel buffer read addresses, waits one cycle for the MAC
// pipeline to drain, then presents the result coordinates to a downstream
// consumer with a valid/ready handshake. Results are emitted in row-major
// order; a one-cycle done pulse marks the end of the job.
//
// All outputs are a pure decode of the registered state and counters, so
// the asynchronous reset clears them immediately without waiting for clk.
module conv_seq_ctrl #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] img_addr,
  output logic [ADDR_W-1:0] ker_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_row,
  output logic [ADDR_W-1:0] out_col,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Geometry constants sized to the address width.
  localparam logic [ADDR_W-1:0] W_L   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] K_L   = ADDR_W'(K);
  localparam logic [ADDR_W-1:0] KM1_L = ADDR_W'(K - 1);
  localparam logic [ADDR_W-1:0] CMAX_L = ADDR_W'(IMG_W - K);
  localparam logic [ADDR_W-1:0] RMAX_L = ADDR_W'(IMG_H - K);
  localparam logic [ADDR_W-1:0] ONE_L  = ADDR_W'(1);

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] row_r, row_nxt_s;   // output row r
  logic [ADDR_W-1:0] col_r, col_nxt_s;   // output column c
  logic [ADDR_W-1:0] kr_r, kr_nxt_s;     // kernel row within window
  logic [ADDR_W-1:0] kc_r, kc_nxt_s;     // kernel column within window

  // State and counter registers; reset aborts any job and returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      row_r   <= '0;
      col_r   <= '0;
      kr_r    <= '0;
      kc_r    <= '0;
    end else begin
      state_r <= state_nxt_s;
      row_r   <= row_nxt_s;
      col_r   <= col_nxt_s;
      kr_r    <= kr_nxt_s;
      kc_r    <= kc_nxt_s;
    end
  end

  // Next-state and counter update; start is only looked at in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    row_nxt_s   = row_r;
    col_nxt_s   = col_r;
    kr_nxt_s    = kr_r;
    kc_nxt_s    = kc_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = CLR;
          row_nxt_s   = '0;
          col_nxt_s   = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLR: begin
        kr_nxt_s    = '0;
        kc_nxt_s    = '0;
        state_nxt_s = MAC;
      end
      MAC: begin
        if (kc_r == KM1_L) begin
          kc_nxt_s = '0;
          if (kr_r == KM1_L) begin
            kr_nxt_s    = '0;
            state_nxt_s = DRAIN;
          end else begin
            kr_nxt_s = kr_r + ONE_L;
          end
        end else begin
          kc_nxt_s = kc_r + ONE_L;
        end
      end
      DRAIN: begin
        state_nxt_s = OUT;
      end
      OUT: begin
        if (out_ready) begin
          if (col_r < CMAX_L) begin
            col_nxt_s   = col_r + ONE_L;
            state_nxt_s = CLR;
          end else if (row_r < RMAX_L) begin
            col_nxt_s   = '0;
            row_nxt_s   = row_r + ONE_L;
            state_nxt_s = CLR;
          end else begin
            state_nxt_s = DONE;
          end
        end else begin
          state_nxt_s = OUT;
        end
      end
      DONE: begin
        row_nxt_s   = '0;
        col_nxt_s   = '0;
        state_nxt_s = IDLE;
      end
      default: begin
        row_nxt_s   = '0;
        col_nxt_s   = '0;
        kr_nxt_s    = '0;
        kc_nxt_s    = '0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output decode from registered state; addresses/coordinates are zero
  // outside the states that own them.
  always_comb begin
    img_addr  = '0;
    ker_addr  = '0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    out_valid = 1'b0;
    out_row   = '0;
    out_col   = '0;
    busy      = (state_r != IDLE);
    done      = 1'b0;
    case (state_r)
      CLR: begin
        mac_clr = 1'b1;
      end
      MAC: begin
        mac_en   = 1'b1;
        img_addr = (row_r + kr_r) * W_L + (col_r + kc_r);
        ker_addr = kr_r * K_L + kc_r;
      end
      OUT: begin
        out_valid = 1'b1;
        out_row   = row_r;
        out_col   = col_r;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        mac_clr = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed testbench for conv_seq_ctrl: default 8x8/K=3 instance plus a
// 4x4/K=4 instance. Expected values are hand-computed constants.
module tb_conv_seq_ctrl;

  logic       clk;
  logic       rst;
  // default-geometry instance
  logic       start0, rdy0;
  logic [7:0] img0, ker0, row0, col0;
  logic       clr0, en0, ov0, busy0, done0;
  // 4x4 image, K=4 instance
  logic       start1, rdy1;
  logic [7:0] img1, ker1, row1, col1;
  logic       clr1, en1, ov1, busy1, done1;

  int n_checks;
  int n_err;
  int cyc, nres, done_cyc, seq_n, cnt, nmac;
  bit pulsed;
  int img_seq [9];
  int ker_seq [9];
  int exp_img [9];

  conv_seq_ctrl dut0 (
    .clk(clk), .rst(rst), .start(start0), .out_ready(rdy0),
    .img_addr(img0), .ker_addr(ker0), .mac_clr(clr0), .mac_en(en0),
    .out_valid(ov0), .out_row(row0), .out_col(col0), .busy(busy0), .done(done0)
  );

  conv_seq_ctrl #(.IMG_W(4), .IMG_H(4), .K(4), .ADDR_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .out_ready(rdy1),
    .img_addr(img1), .ker_addr(ker1), .mac_clr(clr1), .mac_en(en1),
    .out_valid(ov1), .out_row(row1), .out_col(col1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0; n_err = 0;
    rst = 1'b1; start0 = 1'b0; rdy0 = 1'b1; start1 = 1'b0; rdy1 = 1'b1;
    exp_img = '{19, 20, 21, 27, 28, 29, 35, 36, 37};

    // Reset state, before any clock edge.
    #1;
    check("rst_busy0", busy0, 0);
    check("rst_valid0", ov0, 0);
    check("rst_img0", img0, 0);
    check("rst_done0", done0, 0);
    check("rst_busy1", busy1, 0);

    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("idle_after_rst", busy0, 0);

    // Full job, out_ready high; start pulse injected during MAC of (1,1).
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    cyc = 1; nres = 0; done_cyc = 0; seq_n = 0; pulsed = 1'b0;
    check("clr_first", clr0, 1);
    while (done_cyc == 0 && cyc < 1000) begin
      if (ov0) begin
        check("res_row", row0, nres / 6);
        check("res_col", col0, nres % 6);
        check("res_cycle", cyc, 12 * (nres + 1));
        nres++;
      end
      if (en0 && nres == 15 && seq_n < 9) begin
        img_seq[seq_n] = img0;
        ker_seq[seq_n] = ker0;
        seq_n++;
      end
      if (done0) done_cyc = cyc;
      @(posedge clk); #1;
      start0 = 1'b0;
      cyc++;
      if (!pulsed && en0 && nres == 7) begin
        start0 = 1'b1;
        pulsed = 1'b1;
      end
    end
    check("pulse_issued", pulsed, 1);
    check("result_count", nres, 36);
    check("done_cycle", done_cyc, 433);
    check("done_one_cycle", done0, 0);
    check("idle_after_done", busy0, 0);
    check("mac_seq_len", seq_n, 9);
    for (int i = 0; i < 9; i++) begin
      check("r23_img", img_seq[i], exp_img[i]);
      check("r23_ker", ker_seq[i], i);
    end

    // Backpressure at result (0,0).
    rdy0 = 1'b0;
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    cnt = 0;
    while (!ov0 && cnt < 100) begin @(posedge clk); #1; cnt++; end
    check("bp_reach_out", cnt, 11);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) rdy0 = 1'b1;
      check("bp_valid", ov0, 1);
      check("bp_row", row0, 0);
      check("bp_col", col0, 0);
      check("bp_no_en", en0, 0);
      check("bp_no_clr", clr0, 0);
      @(posedge clk); #1;
    end
    check("bp_released", ov0, 0);
    check("bp_next_clr", clr0, 1);

    // Asynchronous reset in the middle of MAC for result (0,1).
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_mac_en", en0, 1);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("abort_busy", busy0, 0);
    check("abort_en", en0, 0);
    check("abort_valid", ov0, 0);
    check("abort_img", img0, 0);
    @(posedge clk); #1;
    check("abort_no_done", done0, 0);
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("abort_idle", busy0, 0);
    check("abort_idle_done", done0, 0);

    // Restart after abort begins again at (0,0).
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    cnt = 0;
    while (!ov0 && cnt < 100) begin @(posedge clk); #1; cnt++; end
    check("restart_latency", cnt, 11);
    check("restart_row", row0, 0);
    check("restart_col", col0, 0);

    // 4x4 image with K=4: single window.
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    cyc = 1; nres = 0; nmac = 0; done_cyc = 0;
    while (done_cyc == 0 && cyc < 200) begin
      if (en1) begin
        check("k4_img", img1, nmac);
        check("k4_ker", ker1, nmac);
        nmac++;
      end
      if (ov1) begin
        check("k4_row", row1, 0);
        check("k4_col", col1, 0);
        check("k4_out_cycle", cyc, 19);
        nres++;
      end
      if (done1) done_cyc = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    check("k4_mac_count", nmac, 16);
    check("k4_result_count", nres, 1);
    check("k4_done_cycle", done_cyc, 20);
    check("k4_idle", busy1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
